// File: rtl/apx_float_multiplier_param.sv
// Multi-cycle parameterised floating-point multiplier with stb/ack handshakes.
// Optional LSB truncation of operands (NAB) trades accuracy for a narrower effective multiply.
module apx_float_multiplier_param #(
    parameter int unsigned EXP_W    = 8,
    parameter int unsigned MAN_W    = 23,
    parameter int unsigned NAB      = 0,
    parameter int unsigned RND_MODE = 1,
    localparam int unsigned W       = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] input_a,
    input  logic         input_a_stb,
    output logic         input_a_ack,
    input  logic [W-1:0] input_b,
    input  logic         input_b_stb,
    output logic         input_b_ack,
    output logic [W-1:0] output_z,
    output logic         output_z_stb,
    input  logic         output_z_ack
);

    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned XW = EXP_W + 3;

    function automatic logic [MAN_W-1:0] frac_mask();
        logic [MAN_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(MAN_W); i++) begin
            m[i] = (i >= int'(NAB));
        end
        return m;
    endfunction

    localparam logic [MAN_W-1:0]     FracMask = frac_mask();
    localparam logic signed [XW-1:0] Bias     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] ExpMax   = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ExpOne   = XW'(1);
    localparam logic signed [XW-1:0] ExpZero  = '0;
    localparam logic [W-1:0]         QNaN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        StGetA, StGetB, StUnpack, StSpecial, StMultiply, StNormalise, StRound, StPack, StPutZ
    } state_e;

    state_e                 state_q, state_d;
    logic                   a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                   z_stb_q, z_stb_d;
    logic [W-1:0]           z_q, z_d;
    logic [W-1:0]           a_q, a_d, b_q, b_d;
    logic                   sign_q, sign_d;
    logic [EXP_W-1:0]       ea_q, ea_d, eb_q, eb_d;
    logic [MAN_W-1:0]       fa_q, fa_d, fb_q, fb_d;
    logic                   special_q, special_d;
    logic [W-1:0]           special_z_q, special_z_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic                   lost_q, lost_d;
    logic [MAN_W-1:0]       frac_q, frac_d;

    // Operand classification; exponent 0 covers denormals, which count as zero.
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    assign a_nan  = (&ea_q) && (|fa_q);
    assign a_inf  = (&ea_q) && !(|fa_q);
    assign a_zero = (ea_q == '0);
    assign b_nan  = (&eb_q) && (|fb_q);
    assign b_inf  = (&eb_q) && !(|fb_q);
    assign b_zero = (eb_q == '0);

    // Leading one sits at bit 2*MAN_W after normalisation.
    logic [MAN_W+1:0] mant, mant_rnd;
    logic             guard, sticky, round_up;
    assign mant     = {1'b0, prod_q[2*MAN_W:MAN_W]};
    assign guard    = prod_q[MAN_W-1];
    assign sticky   = (|prod_q[MAN_W-2:0]) | lost_q;
    assign round_up = (RND_MODE == 1) && guard && (sticky || prod_q[MAN_W]);
    assign mant_rnd = mant + (MAN_W + 2)'(round_up);

    always_comb begin
        state_d     = state_q;
        a_ack_d     = a_ack_q;
        b_ack_d     = b_ack_q;
        z_stb_d     = z_stb_q;
        z_d         = z_q;
        a_d         = a_q;
        b_d         = b_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        fa_d        = fa_q;
        fb_d        = fb_q;
        special_d   = special_q;
        special_z_d = special_z_q;
        exp_d       = exp_q;
        prod_d      = prod_q;
        lost_d      = lost_q;
        frac_d      = frac_q;
        case (state_q)
            StGetA: begin
                if (!a_ack_q) begin
                    a_ack_d = 1'b1;
                end else if (input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    b_ack_d = 1'b1;
                    state_d = StGetB;
                end
            end
            StGetB: begin
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                sign_d  = a_q[W-1] ^ b_q[W-1];
                ea_d    = a_q[W-2:MAN_W];
                eb_d    = b_q[W-2:MAN_W];
                fa_d    = a_q[MAN_W-1:0];
                fb_d    = b_q[MAN_W-1:0];
                state_d = StSpecial;
            end
            StSpecial: begin
                special_d = 1'b1;
                if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                    special_z_d = QNaN;
                end else if (a_inf || b_inf) begin
                    special_z_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (a_zero || b_zero) begin
                    special_z_d = {sign_q, {(W-1){1'b0}}};
                end else begin
                    special_d   = 1'b0;
                    special_z_d = '0;
                end
                state_d = StMultiply;
            end
            StMultiply: begin
                prod_d  = {{(MAN_W+1){1'b0}}, 1'b1, fa_q & FracMask}
                        * {{(MAN_W+1){1'b0}}, 1'b1, fb_q & FracMask};
                exp_d   = $signed({3'b000, ea_q}) + $signed({3'b000, eb_q}) - Bias;
                lost_d  = 1'b0;
                state_d = StNormalise;
            end
            StNormalise: begin
                if (prod_q[PW-1]) begin
                    prod_d = prod_q >> 1;
                    lost_d = prod_q[0];
                    exp_d  = exp_q + ExpOne;
                end
                state_d = StRound;
            end
            StRound: begin
                if (mant_rnd[MAN_W+1]) begin
                    frac_d = mant_rnd[MAN_W:1];
                    exp_d  = exp_q + ExpOne;
                end else begin
                    frac_d = mant_rnd[MAN_W-1:0];
                end
                state_d = StPack;
            end
            StPack: begin
                if (special_q) begin
                    z_d = special_z_q;
                end else if (exp_q >= ExpMax) begin
                    z_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else if (exp_q <= ExpZero) begin
                    z_d = {sign_q, {(W-1){1'b0}}};
                end else begin
                    z_d = {sign_q, exp_q[EXP_W-1:0], frac_q};
                end
                z_stb_d = 1'b1;
                state_d = StPutZ;
            end
            StPutZ: begin
                if (output_z_ack) begin
                    z_stb_d = 1'b0;
                    a_ack_d = 1'b1;
                    state_d = StGetA;
                end
            end
            default: state_d = StGetA;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StGetA;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            z_stb_q     <= 1'b0;
            z_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            fa_q        <= '0;
            fb_q        <= '0;
            special_q   <= 1'b0;
            special_z_q <= '0;
            exp_q       <= '0;
            prod_q      <= '0;
            lost_q      <= 1'b0;
            frac_q      <= '0;
        end else begin
            state_q     <= state_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            z_stb_q     <= z_stb_d;
            z_q         <= z_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            fa_q        <= fa_d;
            fb_q        <= fb_d;
            special_q   <= special_d;
            special_z_q <= special_z_d;
            exp_q       <= exp_d;
            prod_q      <= prod_d;
            lost_q      <= lost_d;
            frac_q      <= frac_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: doc/apx_float_multiplier_param.md
APX_FLOAT_MULTIPLIER_PARAM -- requirements
Module: apx_float_multiplier_param

Interface
REQ-001 SHALL provide parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL provide parameter MAN_W, default 23, stored mantissa fraction width (range 4..52).
REQ-003 SHALL provide parameter NAB, default 0, number of fraction LSBs of each operand forced to zero before multiply (range 0..MAN_W).
REQ-004 SHALL provide parameter RND_MODE, default 1: 0 = truncation, 1 = round-to-nearest-even.
REQ-005 SHALL define W = 1+EXP_W+MAN_W, the operand/result width; format is {sign, exponent, fraction} with bias 2^(EXP_W-1)-1.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 input_a  input  W  operand A.
REQ-009 input_a_stb  input  1  operand A valid.
REQ-010 input_a_ack  output  1  block ready to accept A.
REQ-011 input_b  input  W  operand B.
REQ-012 input_b_stb  input  1  operand B valid.
REQ-013 input_b_ack  output  1  block ready to accept B.
REQ-014 output_z  output  W  product.
REQ-015 output_z_stb  output  1  product valid.
REQ-016 output_z_ack  input  1  consumer accepts product.

Function
REQ-017 SHALL implement states GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z, in that order, returning PUT_Z -> GET_A.
REQ-018 input_a_ack SHALL be 1 only in GET_A; A is captured and the state advances on the edge where input_a_stb && input_a_ack; ack is 0 the following cycle.
REQ-019 input_b_ack SHALL behave identically in GET_B for B; B is never accepted before A.
REQ-020 SHALL wait indefinitely in GET_A/GET_B while the corresponding stb is low.
REQ-021 Latency: output_z_stb SHALL rise exactly 6 cycles after the B-accept edge, independent of operand values or special-case path.
REQ-022 In PUT_Z output_z SHALL be stable and output_z_stb held high until output_z_ack is sampled high; on that edge stb drops and the state returns to GET_A, so input_a_ack is high the next cycle.
REQ-023 Denormal inputs (exponent 0, fraction nonzero) SHALL be treated as signed zero; denormal results SHALL be flushed to signed zero.
REQ-024 Special cases, evaluated on the unmasked operands: any NaN -> canonical quiet NaN {0, all-ones exponent, fraction MSB=1, rest 0}; Inf x 0 -> canonical NaN; Inf x nonzero -> signed Inf; 0 x finite -> signed zero.
REQ-025 Result sign SHALL be sign_a XOR sign_b for all non-NaN results.
REQ-026 MULTIPLY SHALL zero the low NAB fraction bits of each operand, then form the full (2*MAN_W+2)-bit product of the hidden-bit-extended mantissas.
REQ-027 NORMALISE SHALL shift right by one and increment the exponent when the product MSB is set; no other shift is needed.
REQ-028 ROUND SHALL keep MAN_W fraction bits; RND_MODE=0 discards remaining bits; RND_MODE=1 uses guard and sticky (OR of all lower bits) with ties to even; a mantissa carry-out re-normalises and increments the exponent.
REQ-029 Biased exponent >= all-ones after rounding SHALL give signed Inf; biased exponent <= 0 SHALL give signed zero.
REQ-030 With NAB=0, RND_MODE=1, EXP_W=8, MAN_W=23 the result SHALL be bit-identical to IEEE-754 single-precision multiply for all normal, zero, Inf and NaN inputs and normal results.

Reset
REQ-031 While rst=0: state GET_A, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, all internal registers cleared.
REQ-032 First rising edge after rst deasserts SHALL set input_a_ack=1.
REQ-033 Reset asserted in any state, including mid-operation or PUT_Z, SHALL abort the transaction with no output_z_stb pulse; the next transaction SHALL be correct.

Verification
REQ-034 Defaults: A=0x3FC00000, B=0x40000000 -> output_z=0x40400000, stb exactly 6 cycles after B accept.
REQ-035 RND_MODE=1: A=0x3F800001, B=0x3FC00000 -> 0x3FC00002; RND_MODE=0, same inputs -> 0x3FC00001.
REQ-036 NAB=1: A=0x3F800001, B=0x3F800000 -> 0x3F800000; NAB=0 -> 0x3F800001.
REQ-037 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000; 0x7F000000 x 0x7F000000 -> 0x7F800000; 0x80800000 x 0x00800000 -> 0x80000000.
REQ-038 Handshake: hold output_z_ack=0 for 20 cycles -> stb and output_z stable; then ack=1 one cycle -> stb=0 next cycle, input_a_ack=1.
REQ-039 Reset during MULTIPLY -> no stb pulse; then 1.5 x 2.0 -> 0x40400000.
